// File: rtl/exposure_sequencer.sv
// -----------------------------------------------------------------------------
// exposure_sequencer
//
// Runs one capture on the pixel array and ADC. When a capture starts it latches
// the exposure time, clamped to 2..30 units. It then steps through:
//   erase -> expose -> row-1 read (setup, convert) -> row-2 read (setup,
//   convert) -> idle
// A single down-counter times every phase. The counter is loaded on state
// entry, and the state advances when the counter reaches 1.
//
// Parameters
//   TICK_DIV      clk cycles per exposure-time unit (>= 1)
//   ERASE_CYCLES  cycles erase is held high (>= 1)
//   ADC_CYCLES    cycles ADC is held high per row readout (>= 1)
//
// Ports
//   clk      in   single clock, posedge
//   reset    in   synchronous, active-high
//   init     in   capture request (level-sampled in IDLE)
//   ex_time  in   5-bit exposure time in units
//   abort    in   cancel capture (only honoured with EXPOSURE_ABORT_EN)
//   erase    out  sensor erase strobe
//   expose   out  sensor exposure enable
//   NRE_1    out  row-1 read enable, active-low
//   NRE_2    out  row-2 read enable, active-low
//   ADC      out  ADC convert enable
//   busy     out  high in every non-IDLE state
//   done     out  one-cycle pulse in the first IDLE cycle after a capture
//
// Optional feature macro: EXPOSURE_ABORT_EN
//   When it is defined, abort in any non-IDLE state returns to IDLE on the
//   next edge, and abort blocks a start in IDLE. When it is undefined, abort
//   is ignored.
//
// All outputs are registered. Each output register is loaded from the decode
// of the next state, so the outputs always match the state register.
// -----------------------------------------------------------------------------
module exposure_sequencer #(
    parameter int TICK_DIV     = 1,
    parameter int ERASE_CYCLES = 2,
    parameter int ADC_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [4:0] ex_time,
    input  logic       abort,
    output logic       erase,
    output logic       expose,
    output logic       NRE_1,
    output logic       NRE_2,
    output logic       ADC,
    output logic       busy,
    output logic       done
);

    // The counter must hold the longest phase load.
    localparam int EXPOSE_MAX = 30 * TICK_DIV;
    localparam int CNT_MAX_A  = (EXPOSE_MAX > ERASE_CYCLES) ? EXPOSE_MAX : ERASE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_A > ADC_CYCLES) ? CNT_MAX_A : ADC_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES);
    localparam logic [CNT_W-1:0] ADC_LOAD   = CNT_W'(ADC_CYCLES);
    localparam logic [CNT_W-1:0] TICK_LOAD  = CNT_W'(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ERASE     = 3'd1,
        S_EXPOSE    = 3'd2,
        S_RD1_SETUP = 3'd3,
        S_RD1_CONV  = 3'd4,
        S_RD2_SETUP = 3'd5,
        S_RD2_CONV  = 3'd6
    } state_t;

    state_t           state_r;
    state_t           adv_state_s;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] adv_cnt_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] expose_load_s;
    logic [4:0]       time_r;
    logic [4:0]       time_next_s;
    logic             last_s;
    logic             abort_s;
    logic             abort_hit_s;
    logic             adv_done_s;

    logic             erase_r;
    logic             expose_r;
    logic             nre_1_r;
    logic             nre_2_r;
    logic             adc_r;
    logic             busy_r;
    logic             done_r;
    logic             erase_next_s;
    logic             expose_next_s;
    logic             nre_1_next_s;
    logic             nre_2_next_s;
    logic             adc_next_s;
    logic             busy_next_s;
    logic             done_next_s;

    // Out-of-range exposure settings are forced into 2..30 units.
    function automatic logic [4:0] clamp_time(input logic [4:0] t);
        logic [4:0] r;
        if (t < 5'd2) begin
            r = 5'd2;
        end else if (t > 5'd30) begin
            r = 5'd30;
        end else begin
            r = t;
        end
        return r;
    endfunction

`ifdef EXPOSURE_ABORT_EN
    assign abort_s = abort;
`else
    // Without the abort feature the port is present but has no effect.
    logic unused_abort_s;
    assign unused_abort_s = abort;
    assign abort_s        = 1'b0;
`endif

    assign last_s        = (cnt_r == CNT_ONE);
    assign expose_load_s = CNT_W'(time_r) * TICK_LOAD;

    // Normal sequencing: next state, counter reload/decrement, time latch.
    always_comb begin
        adv_state_s = state_r;
        adv_cnt_s   = cnt_r;
        adv_done_s  = 1'b0;
        time_next_s = time_r;
        case (state_r)
            S_IDLE: begin
                // abort in the same cycle as init blocks the start.
                if (init && !abort_s) begin
                    adv_state_s = S_ERASE;
                    adv_cnt_s   = ERASE_LOAD;
                    time_next_s = clamp_time(ex_time);
                end else begin
                    adv_cnt_s = CNT_ZERO;
                end
            end
            S_ERASE: begin
                if (last_s) begin
                    adv_state_s = S_EXPOSE;
                    adv_cnt_s   = expose_load_s;
                end else begin
                    adv_cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_EXPOSE: begin
                if (last_s) begin
                    adv_state_s = S_RD1_SETUP;
                    adv_cnt_s   = CNT_ONE;
                end else begin
                    adv_cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_RD1_SETUP: begin
                if (last_s) begin
                    adv_state_s = S_RD1_CONV;
                    adv_cnt_s   = ADC_LOAD;
                end else begin
                    adv_cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_RD1_CONV: begin
                if (last_s) begin
                    adv_state_s = S_RD2_SETUP;
                    adv_cnt_s   = CNT_ONE;
                end else begin
                    adv_cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_RD2_SETUP: begin
                if (last_s) begin
                    adv_state_s = S_RD2_CONV;
                    adv_cnt_s   = ADC_LOAD;
                end else begin
                    adv_cnt_s = cnt_r - CNT_ONE;
                end
            end
            S_RD2_CONV: begin
                if (last_s) begin
                    adv_state_s = S_IDLE;
                    adv_cnt_s   = CNT_ZERO;
                    adv_done_s  = 1'b1;
                end else begin
                    adv_cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                adv_state_s = S_IDLE;
                adv_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // abort overrides normal advance. It returns to IDLE without a done pulse.
    assign abort_hit_s  = abort_s && (state_r != S_IDLE);
    assign state_next_s = abort_hit_s ? S_IDLE : adv_state_s;
    assign cnt_next_s   = abort_hit_s ? CNT_ZERO : adv_cnt_s;
    assign done_next_s  = abort_hit_s ? 1'b0 : adv_done_s;

    // Moore decode of the next state. It feeds the output registers.
    assign erase_next_s  = (state_next_s == S_ERASE);
    assign expose_next_s = (state_next_s == S_EXPOSE);
    assign nre_1_next_s  = !((state_next_s == S_RD1_SETUP) || (state_next_s == S_RD1_CONV));
    assign nre_2_next_s  = !((state_next_s == S_RD2_SETUP) || (state_next_s == S_RD2_CONV));
    assign adc_next_s    = (state_next_s == S_RD1_CONV) || (state_next_s == S_RD2_CONV);
    assign busy_next_s   = (state_next_s != S_IDLE);

    // State, counter, latched time and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= CNT_ZERO;
            time_r   <= 5'd2;
            erase_r  <= 1'b0;
            expose_r <= 1'b0;
            nre_1_r  <= 1'b1;
            nre_2_r  <= 1'b1;
            adc_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            time_r   <= time_next_s;
            erase_r  <= erase_next_s;
            expose_r <= expose_next_s;
            nre_1_r  <= nre_1_next_s;
            nre_2_r  <= nre_2_next_s;
            adc_r    <= adc_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
        end
    end

    assign erase  = erase_r;
    assign expose = expose_r;
    assign NRE_1  = nre_1_r;
    assign NRE_2  = nre_2_r;
    assign ADC    = adc_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_exposure_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exposure_sequencer
//
// Bench for exposure_sequencer. It instantiates the default build (TICK_DIV=1)
// and a TICK_DIV=4 copy, and drives both from the same inputs.
//
// A behavioural model follows each copy. The model tracks the capture as a
// cycle offset k from the start edge, and derives every output from the phase
// boundaries of the capture.
//
// The bench also runs a table of exposure settings and hand-written corner
// sequences.
// -----------------------------------------------------------------------------
module tb_exposure_sequencer;

    localparam int E = 2;
    localparam int A = 2;
`ifdef EXPOSURE_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif
    localparam logic [6:0] RESET_VEC = 7'b0011000;   // {erase,expose,NRE_1,NRE_2,ADC,busy,done}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset   = 1'b1;
    logic       init    = 1'b0;
    logic       abort   = 1'b0;
    logic [4:0] ex_time = 5'd0;

    logic erase1, expose1, nre1_1, nre2_1, adc1, busy1, done1;
    logic erase4, expose4, nre1_4, nre2_4, adc4, busy4, done4;

    exposure_sequencer dut (
        .clk(clk), .reset(reset), .init(init), .ex_time(ex_time), .abort(abort),
        .erase(erase1), .expose(expose1), .NRE_1(nre1_1), .NRE_2(nre2_1),
        .ADC(adc1), .busy(busy1), .done(done1)
    );

    exposure_sequencer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .init(init), .ex_time(ex_time), .abort(abort),
        .erase(erase4), .expose(expose4), .NRE_1(nre1_4), .NRE_2(nre2_4),
        .ADC(adc4), .busy(busy4), .done(done4)
    );

    wire [6:0] out1 = {erase1, expose1, nre1_1, nre2_1, adc1, busy1, done1};
    wire [6:0] out4 = {erase4, expose4, nre1_4, nre2_4, adc4, busy4, done4};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit active;
        int k;      // cycle number within the capture, 1 = first erase cycle
        int t;      // latched exposure units
        bit done;
    } model_t;

    model_t m1 = '{1'b0, 0, 2, 1'b0};
    model_t m4 = '{1'b0, 0, 2, 1'b0};

    function automatic int clamp_t(input logic [4:0] x);
        int v = int'(x);
        return (v < 2) ? 2 : ((v > 30) ? 30 : v);
    endfunction

    function automatic int cap_len(input int t, input int d);
        return E + t * d + 2 * (1 + A);
    endfunction

    function automatic model_t model_step(input model_t m, input logic i_init, input logic [4:0] i_ex,
                                          input logic i_rst, input logic i_abort, input int d);
        model_t n = m;
        n.done = 1'b0;
        if (i_rst) begin
            n.active = 1'b0;
            n.k      = 0;
        end else if (m.active) begin
            if (ABORT_EN && i_abort) begin
                n.active = 1'b0;
            end else if (m.k == cap_len(m.t, d)) begin
                n.active = 1'b0;
                n.done   = 1'b1;
            end else begin
                n.k = m.k + 1;
            end
        end else if (i_init && !(ABORT_EN && i_abort)) begin
            n.active = 1'b1;
            n.k      = 1;
            n.t      = clamp_t(i_ex);
        end
        return n;
    endfunction

    function automatic logic [6:0] model_out(input model_t m, input int d);
        logic [6:0] o;
        int td, r1, r2;
        if (!m.active) begin
            o = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m.done};
        end else begin
            td   = m.t * d;
            r1   = E + td;          // last expose cycle
            r2   = r1 + 1 + A;      // last row-1 cycle
            o[6] = (m.k <= E);
            o[5] = (m.k > E) && (m.k <= r1);
            o[4] = !((m.k > r1) && (m.k <= r2));
            o[3] = !((m.k > r2) && (m.k <= r2 + 1 + A));
            o[2] = ((m.k > r1 + 1) && (m.k <= r2)) || ((m.k > r2 + 1) && (m.k <= r2 + 1 + A));
            o[1] = 1'b1;
            o[0] = 1'b0;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        m1 <= model_step(m1, init, ex_time, reset, abort, 1);
        m4 <= model_step(m4, init, ex_time, reset, abort, 4);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_d1", {25'd0, out1}, {25'd0, model_out(m1, 1)});
            check("model_d4", {25'd0, out4}, {25'd0, model_out(m4, 4)});
        end
    end

    // ---------------- helpers ----------------
    // Pulses init for one cycle. Returns the expose length and done cycle of both copies.
    task automatic run_capture(input logic [4:0] ex, output int x1, output int d1,
                               output int x4, output int d4);
        int c;
        x1 = 0; x4 = 0; d1 = -1; d4 = -1;
        ex_time = ex;
        init    = 1'b1;
        @(negedge clk);
        init = 1'b0;
        c    = 1;
        while (c <= 200 && (d1 < 0 || d4 < 0)) begin
            if (expose1) x1++;
            if (expose4) x4++;
            if (done1 && d1 < 0) d1 = c;
            if (done4 && d4 < 0) d4 = c;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || busy4) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, (n < 400)}, 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] ex;
        int         expose1;
        int         done1;
        int         expose4;
        int         done4;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   x1, d1, x4, d4, c, cnt, dcnt, ecnt, fall, st0, st1, nst;
        logic prev_e;

        // Done cycle = E + T*D + 2*(1+A) + 1 = T*D + 9
        vecs[0] = '{5'd15, 15, 24,  60,  69};
        vecs[1] = '{5'd0,   2, 11,   8,  17};
        vecs[2] = '{5'd1,   2, 11,   8,  17};
        vecs[3] = '{5'd31, 30, 39, 120, 129};
        vecs[4] = '{5'd30, 30, 39, 120, 129};
        vecs[5] = '{5'd2,   2, 11,   8,  17};
        vecs[6] = '{5'd7,   7, 16,  28,  37};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_d1", {25'd0, out1}, {25'd0, RESET_VEC});
        check("reset_d4", {25'd0, out4}, {25'd0, RESET_VEC});
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Table of exposure settings, including the clamp boundaries
        for (int i = 0; i < 7; i++) begin
            run_capture(vecs[i].ex, x1, d1, x4, d4);
            check($sformatf("vec%0d_expose_d1", i), x1, vecs[i].expose1);
            check($sformatf("vec%0d_done_d1", i),   d1, vecs[i].done1);
            check($sformatf("vec%0d_expose_d4", i), x4, vecs[i].expose4);
            check($sformatf("vec%0d_done_d4", i),   d4, vecs[i].done4);
            wait_idle();
        end

        // ex_time change mid-capture and init while busy are both ignored
        ex_time = 5'd15; init = 1'b1;
        @(negedge clk);
        init = 1'b0; cnt = 0; dcnt = 0; ecnt = 0; fall = -1;
        for (c = 1; c <= 40; c++) begin
            if (expose1) cnt++;
            if (erase1) ecnt++;
            if (done1) dcnt++;
            if (!busy1 && fall < 0) fall = c;
            if (c == 3) ex_time = 5'd20;
            init = (c == 10);
            @(negedge clk);
        end
        check("chg_expose", cnt, 15);
        check("chg_busy_fall", fall, 24);
        check("chg_done_cnt", dcnt, 1);
        check("chg_erase_cnt", ecnt, 2);
        wait_idle();

        // init held high for 60 cycles gives back-to-back captures
        ex_time = 5'd15; init = 1'b1;
        @(negedge clk);
        prev_e = 1'b0; st0 = -1; st1 = -1; nst = 0; dcnt = 0;
        for (c = 1; c <= 60; c++) begin
            if (erase1 && !prev_e) begin
                if (nst == 0) st0 = c;
                if (nst == 1) st1 = c;
                nst++;
            end
            if (done1) dcnt++;
            prev_e = erase1;
            @(negedge clk);
        end
        init = 1'b0;
        check("held_start0", st0, 1);
        check("held_start1", st1, 25);
        check("held_done_cnt", dcnt, 2);
        wait_idle();

        // Reset during RD1_CONV, then a clean restart
        ex_time = 5'd15; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (c = 1; c < 19; c++) @(negedge clk);
        check("rst_pre_adc", {31'd0, adc1}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_d1", {25'd0, out1}, {25'd0, RESET_VEC});
        reset = 1'b0;
        @(negedge clk);
        check("rst_no_done", {31'd0, done1}, 32'd0);
        run_capture(5'd15, x1, d1, x4, d4);
        check("rst_restart_expose", x1, 15);
        check("rst_restart_done", d1, 24);
        wait_idle();

        // abort at cycle 10
        ex_time = 5'd15; init = 1'b1;
        @(negedge clk);
        init = 1'b0; d1 = -1;
        for (c = 1; c <= 40; c++) begin
            if (c == 11) check("abort_c11", {25'd0, out1}, {25'd0, (ABORT_EN ? RESET_VEC : 7'b0111010)});
            if (done1 && d1 < 0) d1 = c;
            abort = (c == 10);
            @(negedge clk);
        end
        check("abort_done", d1, ABORT_EN ? -1 : 24);
        wait_idle();

        // abort together with init in IDLE
        init = 1'b1; abort = 1'b1;
        @(negedge clk);
        init = 1'b0; abort = 1'b0;
        check("abort_init_idle", {31'd0, busy1}, {31'd0, !ABORT_EN});
        wait_idle();

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            init    = ($urandom_range(0, 11) == 0);
            ex_time = 5'($urandom);
            abort   = ($urandom_range(0, 59) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        init = 1'b0; abort = 1'b0; reset = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
